// File: rtl/block_pkg.sv
// rtl/block_pkg.sv - token encodings, ASCII constants and token lengths for the block stream generator
package block_pkg;

  localparam logic [1:0] TOK_BEGIN = 2'd0;
  localparam logic [1:0] TOK_END   = 2'd1;
  localparam logic [1:0] TOK_SPACE = 2'd2;
  localparam logic [1:0] TOK_CHAR  = 2'd3;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] CASE_DELTA  = 8'h20;

  localparam logic [2:0] LEN_BEGIN = 3'd6;
  localparam logic [2:0] LEN_END   = 3'd4;

  typedef enum logic {ST_IDLE, ST_EMIT} state_t;

  // Index of the final character of a token; single-character tokens end at 0.
  function automatic logic [2:0] last_idx(input logic [1:0] t);
    case (t)
      TOK_BEGIN: return LEN_BEGIN - 3'd1;
      TOK_END:   return LEN_END - 3'd1;
      default:   return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/block_char_rom.sv
// rtl/block_char_rom.sv - maps a token, character index and case mask to one ASCII byte
module block_char_rom
  import block_pkg::*;
(
  input  logic [1:0] tok_type,
  input  logic [2:0] idx,
  input  logic [4:0] tok_case,
  input  logic [7:0] tok_char,
  output logic [7:0] ch
);

  logic [7:0] base;
  logic       up;

  always_comb begin
    base = ASCII_SPACE;
    up   = 1'b0;
    case (tok_type)
      TOK_BEGIN: begin
        case (idx)
          3'd0: begin base = 8'h62; up = tok_case[0]; end
          3'd1: begin base = 8'h65; up = tok_case[1]; end
          3'd2: begin base = 8'h67; up = tok_case[2]; end
          3'd3: begin base = 8'h69; up = tok_case[3]; end
          3'd4: begin base = 8'h6e; up = tok_case[4]; end
          default: base = ASCII_SPACE;
        endcase
      end
      TOK_END: begin
        case (idx)
          3'd0: begin base = 8'h65; up = tok_case[0]; end
          3'd1: begin base = 8'h6e; up = tok_case[1]; end
          3'd2: begin base = 8'h64; up = tok_case[2]; end
          default: base = ASCII_SPACE;
        endcase
      end
      TOK_SPACE: base = ASCII_SPACE;
      default:   base = tok_char;
    endcase
    ch = up ? (base - CASE_DELTA) : base;
  end

endmodule

// File: rtl/block_stream_gen.sv
// rtl/block_stream_gen.sv - serialises begin/end/space/char tokens to ASCII and tracks nesting depth
module block_stream_gen
  import block_pkg::*;
#(
  parameter int DEPTH_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tok_valid,
  input  logic [1:0]         tok_type,
  input  logic [4:0]         tok_case,
  input  logic [7:0]         tok_char,
  output logic               tok_ready,
  output logic [7:0]         out,
  output logic               out_valid,
  output logic [DEPTH_W-1:0] depth,
  output logic               underflow,
  output logic               overflow,
  output logic               balanced
);

  localparam logic [DEPTH_W-1:0] DEPTH_MAX = '1;

  state_t     state;
  logic [1:0] l_type;
  logic [4:0] l_case;
  logic [7:0] l_char;
  logic [2:0] idx;

  logic       at_last;
  logic       accept;
  logic [1:0] rom_type;
  logic [2:0] rom_idx;
  logic [4:0] rom_case;
  logic [7:0] rom_char;
  logic [7:0] rom_ch;

  assign at_last   = (state == ST_EMIT) && (idx == last_idx(l_type));
  assign tok_ready = (state == ST_IDLE) || at_last;
  assign accept    = tok_valid && tok_ready;
  assign balanced  = (depth == '0) && !underflow && !overflow;

  // One ROM serves both the first char of a newly accepted token and the next char of the current one.
  always_comb begin
    rom_type = l_type;
    rom_idx  = idx + 3'd1;
    rom_case = l_case;
    rom_char = l_char;
    if (accept) begin
      rom_type = tok_type;
      rom_idx  = 3'd0;
      rom_case = tok_case;
      rom_char = tok_char;
    end
  end

  block_char_rom u_rom (
    .tok_type (rom_type),
    .idx      (rom_idx),
    .tok_case (rom_case),
    .tok_char (rom_char),
    .ch       (rom_ch)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      idx       <= 3'd0;
      l_type    <= TOK_BEGIN;
      l_case    <= 5'd0;
      l_char    <= 8'h00;
      out       <= 8'h00;
      out_valid <= 1'b0;
      depth     <= '0;
      underflow <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      // Depth commits while the trailing space is on the wire, matching the checker's view.
      if (at_last) begin
        if (l_type == TOK_BEGIN) begin
          if (depth == DEPTH_MAX) overflow <= 1'b1;
          else                    depth    <= depth + 1'b1;
        end else if (l_type == TOK_END) begin
          if (depth == '0) underflow <= 1'b1;
          else             depth     <= depth - 1'b1;
        end
      end

      if (accept) begin
        state     <= ST_EMIT;
        idx       <= 3'd0;
        l_type    <= tok_type;
        l_case    <= tok_case;
        l_char    <= tok_char;
        out       <= rom_ch;
        out_valid <= 1'b1;
      end else if (at_last) begin
        state     <= ST_IDLE;
        out       <= 8'h00;
        out_valid <= 1'b0;
      end else if (state == ST_EMIT) begin
        idx <= idx + 3'd1;
        out <= rom_ch;
      end
    end
  end

endmodule

// File: tb/tb_block_stream_gen.sv
// tb/tb_block_stream_gen.sv - scoreboard bench for block_stream_gen with a string-level reference model
module tb_block_stream_gen;

  localparam int DW   = 2;
  localparam int MAXD = (1 << DW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          tok_valid = 1'b0;
  logic [1:0]    tok_type = 2'd0;
  logic [4:0]    tok_case = 5'd0;
  logic [7:0]    tok_char = 8'h00;
  logic          tok_ready;
  logic [7:0]    out;
  logic          out_valid;
  logic [DW-1:0] depth;
  logic          underflow;
  logic          overflow;
  logic          balanced;

  block_stream_gen #(.DEPTH_W(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .tok_valid (tok_valid),
    .tok_type  (tok_type),
    .tok_case  (tok_case),
    .tok_char  (tok_char),
    .tok_ready (tok_ready),
    .out       (out),
    .out_valid (out_valid),
    .depth     (depth),
    .underflow (underflow),
    .overflow  (overflow),
    .balanced  (balanced)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] ch;
    bit         last;
    int         dep;
    bit         uf;
    bit         of;
  } exp_t;

  exp_t sb[$];
  int   asserts = 0;
  int   fails = 0;
  int   mdep = 0;
  bit   muf = 0;
  bit   mof = 0;
  bit   mon_en = 0;

  task automatic chk(input string name, input int act, input int exp);
    asserts++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: the token's text as a string, letters upper-cased by mask, depth as saturating integer.
  task automatic model_token(input logic [1:0] t, input logic [4:0] c, input logic [7:0] ch);
    string      s;
    logic [7:0] b;
    exp_t       e;
    case (t)
      2'd0:    s = "begin ";
      2'd1:    s = "end ";
      2'd2:    s = " ";
      default: s = "";
    endcase
    if (t == 2'd3) begin
      e.ch = ch; e.last = 1'b1; e.dep = mdep; e.uf = muf; e.of = mof;
      sb.push_back(e);
    end else begin
      for (int i = 0; i < s.len(); i++) begin
        b = s[i];
        if (i < 5 && b != 8'h20) begin
          if (c[i]) b = b - 8'h20;
        end
        e.ch = b; e.last = (i == s.len() - 1); e.dep = mdep; e.uf = muf; e.of = mof;
        sb.push_back(e);
      end
    end
    if (t == 2'd0) begin
      if (mdep == MAXD) mof = 1'b1;
      else              mdep++;
    end else if (t == 2'd1) begin
      if (mdep == 0) muf = 1'b1;
      else           mdep--;
    end
  endtask

  task automatic send(input logic [1:0] t, input logic [4:0] c, input logic [7:0] ch, input bit hold);
    bit rdy;
    bit ok;
    ok = 1'b0;
    tok_valid = 1'b1;
    tok_type  = t;
    tok_case  = c;
    tok_char  = ch;
    for (int n = 0; n < 20 && !ok; n++) begin
      rdy = tok_ready;
      @(posedge clk);
      #1;
      ok = rdy;
    end
    chk("accept_timeout", ok, 1);
    if (ok) model_token(t, c, ch);
    if (!hold) begin
      tok_valid = 1'b0;
      tok_type  = 2'($urandom);
      tok_case  = 5'($urandom);
      tok_char  = 8'($urandom);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tok_valid = 1'b0;
    @(posedge clk);
    #1;
    sb.delete();
    mdep = 0; muf = 0; mof = 0;
    chk("rst_out", out, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_tok_ready", tok_ready, 1);
    chk("rst_depth", depth, 0);
    chk("rst_underflow", underflow, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_balanced", balanced, 1);
    reset = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_timeout", sb.size(), 0);
    @(posedge clk);
    #1;
    chk("idle_out_valid", out_valid, 0);
    chk("idle_depth", depth, mdep);
    chk("idle_underflow", underflow, muf);
    chk("idle_overflow", overflow, mof);
    chk("idle_balanced", balanced, (mdep == 0 && !muf && !mof));
  endtask

  initial begin
    exp_t e;
    wait (mon_en);
    forever begin
      @(negedge clk);
      if (out_valid) begin
        if (sb.size() == 0) begin
          chk("spurious_out_valid", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("char", out, e.ch);
          chk("ready_on_last", tok_ready, e.last);
          chk("depth_stream", depth, e.dep);
          chk("underflow_stream", underflow, e.uf);
          chk("overflow_stream", overflow, e.of);
          chk("balanced_stream", balanced, (e.dep == 0 && !e.uf && !e.of));
        end
      end else begin
        chk("gap_pending_chars", sb.size(), 0);
        chk("ready_idle", tok_ready, 1);
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    mon_en = 1'b1;

    send(2'd0, 5'b10000, 8'h00, 1'b1);
    send(2'd1, 5'b00000, 8'h00, 1'b0);
    wait_idle();

    send(2'd1, 5'b00000, 8'h00, 1'b0);
    wait_idle();
    send(2'd0, 5'b01010, 8'h00, 1'b1);
    send(2'd1, 5'b00101, 8'h00, 1'b0);
    wait_idle();

    do_reset();
    for (int i = 0; i < 4; i++) send(2'd0, 5'($urandom), 8'h00, (i != 3));
    wait_idle();

    do_reset();
    send(2'd0, 5'b00001, 8'h00, 1'b1);
    send(2'd3, 5'b11111, 8'h78, 1'b1);
    send(2'd2, 5'b11111, 8'h00, 1'b0);
    wait_idle();

    send(2'd0, 5'b00000, 8'h00, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    do_reset();
    send(2'd0, 5'b00000, 8'h00, 1'b0);
    wait_idle();

    do_reset();
    for (int i = 0; i < 150; i++) begin
      bit hold;
      hold = 1'($urandom);
      send(2'($urandom), 5'($urandom), 8'($urandom), hold);
      if (!hold) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    tok_valid = 1'b0;
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
